// File: rtl/lockin_channel_scheduler.sv
// lockin_channel_scheduler: time-multiplexes one lock-in datapath across a table of reference tuning words,
// running one pass per enabled channel for each filled half of the audio double buffer.
module lockin_channel_scheduler #(
    parameter int NUM_CHANNELS      = 4,
    parameter int FREQUENCY_SIZE_IN = 13,
    parameter int TIMEOUT_CYCLES    = 8192
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic                            cfg_wr_en,
    input  logic [$clog2(NUM_CHANNELS)-1:0] cfg_wr_ch,
    input  logic [FREQUENCY_SIZE_IN-1:0]    cfg_wr_word,
    input  logic [NUM_CHANNELS-1:0]         channel_mask,
    input  logic                            buffer_ready,
    output logic                            buffer_release,
    output logic                            lockin_go,
    output logic [FREQUENCY_SIZE_IN-1:0]    tuning_word_out,
    input  logic                            lockin_done,
    output logic [$clog2(NUM_CHANNELS)-1:0] active_channel,
    output logic                            busy,
    output logic                            overrun,
    output logic                            timeout_err,
    output logic [15:0]                     sweep_count
);
    localparam int CW = $clog2(NUM_CHANNELS);
    localparam int PW = CW + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SELECT    = 3'd1;
    localparam logic [2:0] LAUNCH    = 3'd2;
    localparam logic [2:0] GO        = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] RELEASE   = 3'd5;

    logic [2:0]                   state;
    logic [FREQUENCY_SIZE_IN-1:0] tune_table [2**CW];
    logic [PW-1:0]                ptr;
    logic [WW-1:0]                watchdog;
    logic                         buffer_ready_q;
    logic                         rise;
    logic                         found;
    logic                         pass_end;
    logic [CW-1:0]                next_ch;

    assign rise     = buffer_ready & ~buffer_ready_q;
    assign busy     = state != IDLE;
    assign pass_end = lockin_done || watchdog == WW'(TIMEOUT_CYCLES - 1);

    // lowest enabled channel at or above ptr; ptr == NUM_CHANNELS naturally finds nothing
    always_comb begin
        found   = 1'b0;
        next_ch = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (channel_mask[i] && PW'(i) >= ptr) begin
                found   = 1'b1;
                next_ch = CW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2**CW; i++) tune_table[i] <= '0;
        end else if (cfg_wr_en) begin
            tune_table[cfg_wr_ch] <= cfg_wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            ptr             <= '0;
            watchdog        <= '0;
            buffer_ready_q  <= 1'b0;
            buffer_release  <= 1'b0;
            lockin_go       <= 1'b0;
            tuning_word_out <= '0;
            active_channel  <= '0;
            overrun         <= 1'b0;
            timeout_err     <= 1'b0;
            sweep_count     <= '0;
        end else begin
            buffer_ready_q <= buffer_ready;
            buffer_release <= 1'b0;
            lockin_go      <= 1'b0;
            timeout_err    <= 1'b0;
            overrun        <= rise && busy;
            case (state)
                IDLE: begin
                    if (rise && enable) begin
                        state <= SELECT;
                        ptr   <= '0;
                    end
                end
                SELECT: begin
                    state <= found ? LAUNCH : RELEASE;
                    if (found) active_channel <= next_ch;
                end
                LAUNCH: begin
                    tuning_word_out <= tune_table[active_channel];
                    watchdog        <= '0;
                    state           <= GO;
                end
                GO: begin
                    lockin_go <= 1'b1;
                    watchdog  <= watchdog + WW'(1);
                    state     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    watchdog <= watchdog + WW'(1);
                    if (pass_end) begin
                        timeout_err <= !lockin_done;
                        ptr         <= PW'(active_channel) + PW'(1);
                        state       <= SELECT;
                    end
                end
                RELEASE: begin
                    buffer_release <= 1'b1;
                    sweep_count    <= sweep_count + 16'd1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lockin_channel_scheduler.md
Name: lockin_channel_scheduler

Overview:
- Multi-frequency sequencer in front of the lock-in controller; one shared DDFS/mixer/CIC datapath is time-multiplexed across NUM_CHANNELS reference frequencies.
- On each new filled half of the audio double buffer, runs one full-buffer lock-in pass per enabled channel, lowest index first.
- Presents each pass's tuning word, launches it, waits for completion, then releases the buffer half back to the double buffer.

Parameters:
- NUM_CHANNELS, 4: number of reference-frequency slots.
- FREQUENCY_SIZE_IN, 13: tuning word width, matching the lock-in controller input.
- TIMEOUT_CYCLES, 8192: watchdog limit per pass, in clk cycles.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  level; 0 blocks new sweeps from starting.
- cfg_wr_en  input  1  tuning-table write strobe.
- cfg_wr_ch  input  $clog2(NUM_CHANNELS)  table slot to write.
- cfg_wr_word  input  FREQUENCY_SIZE_IN  tuning word to write.
- channel_mask  input  NUM_CHANNELS  bit i=1 enables channel i.
- buffer_ready  input  1  level from double buffer; high = a filled half is available.
- buffer_release  output  1  1-cycle pulse; current half fully consumed.
- lockin_go  output  1  1-cycle pulse; drives lock-in controller buffer_ready.
- tuning_word_out  output  FREQUENCY_SIZE_IN  drives lock-in controller tuning_word_in.
- lockin_done  input  1  1-cycle pulse; lock-in pass complete (last sample to CIC).
- active_channel  output  $clog2(NUM_CHANNELS)  channel of current/last pass.
- busy  output  1  high in every state except IDLE.
- overrun  output  1  1-cycle pulse; buffer_ready rose while busy.
- timeout_err  output  1  1-cycle pulse; watchdog expired.
- sweep_count  output  16  completed sweeps; wraps at 2^16.

Behaviour:
- Async reset (reset_n=0):
  - state IDLE, all outputs 0, tuning table cleared to 0, buffer_ready_q=0, watchdog=0.
  - Reset asserted mid-pass aborts the pass immediately; no release pulse is produced.
- Table writes:
  - Accepted any cycle cfg_wr_en=1.
  - tuning_word_out is registered at LAUNCH only, so a write to the running channel affects the next pass, not the current one.
  - A write in the same cycle as LAUNCH reads the old value.
- Edge detect: rise = buffer_ready & ~buffer_ready_q; buffer_ready_q registered every cycle.
- FSM:
  - IDLE:
    - rise & enable -> SELECT, channel pointer ptr=0.
    - rise & ~enable: event ignored, no release.
  - SELECT:
    - Finds lowest i>=ptr with channel_mask[i]=1 (mask sampled live).
    - Found: active_channel<=i, go to LAUNCH.
    - None found: go to RELEASE. An all-zero mask releases the buffer with no pass.
  - LAUNCH:
    - tuning_word_out<=table[active_channel], watchdog cleared, go to GO.
  - GO:
    - lockin_go<=1 for one cycle, go to WAIT_DONE.
    - Tuning word is therefore stable at least one cycle before go.
  - WAIT_DONE:
    - lockin_done -> ptr<=active_channel+1, go to SELECT.
    - ptr==NUM_CHANNELS is treated as none found.
    - Watchdog reaches TIMEOUT_CYCLES-1: timeout_err pulse, then same as done.
    - lockin_done and watchdog expiry in the same cycle: done wins, no error.
  - RELEASE:
    - buffer_release=1 for one cycle, sweep_count++, go to IDLE.
- Latency:
  - Rise sampled at clock edge E0 -> lockin_go high in the cycle following E3. Sequence: SELECT@E0, LAUNCH@E1, GO@E2, pulse registered @E3.
  - lockin_done at edge D -> next lockin_go after D+3.
  - Last done -> buffer_release registered at D+2.
- enable deasserted mid-sweep: sweep completes normally, including release; enable is checked only in IDLE.
- overrun: pulses on any rise while state != IDLE; that event is dropped.
- Mask change mid-sweep: affects only channels not yet selected.
- All outputs are registered; no combinational path from input to output.

Test Plan:
- Reset, write table {100,200,300,400}, mask=4'b1111, raise buffer_ready, answer each lockin_go with lockin_done 10 cycles later -> 4 go pulses with tuning_word_out 100,200,300,400 and active_channel 0..3, then one buffer_release, sweep_count=1.
- mask=4'b1010 -> exactly 2 passes (words 200,400); mask=4'b0000 -> no lockin_go, buffer_release 2 cycles after the rise edge.
- Withhold lockin_done with TIMEOUT_CYCLES=16 -> timeout_err pulse 16 cycles after LAUNCH, sweep continues to the next channel, release still issued.
- Toggle buffer_ready low-high during WAIT_DONE -> overrun pulse, sweep_count advances by only 1; write channel 1 during its pass -> current tuning_word_out unchanged, new value used next sweep.
- Assert reset_n low asynchronously mid-WAIT_DONE -> all outputs 0 immediately, busy=0, no buffer_release; lockin_done and timeout in the same cycle -> no timeout_err.
